wb_master_port: RTL and testbench

- Wishbone pipelined-mode initiator that turns one CPU load/store request into exactly one single-beat bus transaction.
- Sits between the CPU load/store stage and the system bus, and drives the bus's stb/we/addr/data/sel inputs.
- Consumes the bus's ack/stall/data outputs and returns a single response to the CPU.
- Adds a misalignment check and an ack timeout, so a dead address never hangs the pipeline.

---
 rtl/wb_master_port_pkg.sv | 30 +++
 rtl/wb_master_port_if.sv | 36 +++
 rtl/wb_master_port.sv | 149 ++++++++++++++
 tb/tb_wb_master_port.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_port_pkg.sv
// Shared definitions for the Wishbone pipelined single-beat initiator.
package wb_master_port_pkg;

  // CPU size codes, forwarded unchanged onto the bus select lines
  localparam logic [2:0] SEL_B  = 3'b000;
  localparam logic [2:0] SEL_H  = 3'b001;
  localparam logic [2:0] SEL_W  = 3'b010;
  localparam logic [2:0] SEL_BU = 3'b100;
  localparam logic [2:0] SEL_HU = 3'b101;

  // Response data reported for misaligned or timed-out accesses
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((size == SEL_H) || (size == SEL_HU)) mis = addr_lo[0];
    else if (size == SEL_W)                  mis = |addr_lo;
    return mis;
  endfunction

endpackage

// File: rtl/wb_master_port_if.sv
// CPU request/response and Wishbone bus signals of the initiator port.
interface wb_master_port_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [2:0]  i_req_size;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [2:0]  o_wb_sel;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;

  // Initiator (design) view
  modport master (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size,
    input  i_wb_data, i_wb_ack, i_wb_stall,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );

  // CPU + bus environment view
  modport slave (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size,
    output i_wb_data, i_wb_ack, i_wb_stall,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
  );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone pipelined-mode initiator: one CPU load/store becomes exactly one
// single-beat bus transaction, with misalignment rejection and ack timeout.
module wb_master_port
  import wb_master_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  wb_master_port_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timed_out;
  logic [CNT_W-1:0]  cnt_inc;

  assign bus.o_req_ready = (state_q == ST_IDLE);
  assign bus.o_wb_stb    = stb_q;
  assign bus.o_wb_we     = we_q;
  assign bus.o_wb_addr   = addr_q;
  assign bus.o_wb_data   = wdata_q;
  assign bus.o_wb_sel    = sel_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;

  // Outstanding-cycle count: the current cycle is the last allowed one
  // when the count already equals TIMEOUT_CYCLES-1.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Next-state, bus strobe, capture and response logic
  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          we_d    = bus.i_req_we;
          addr_d  = bus.i_req_addr;
          wdata_d = bus.i_req_wdata;
          sel_d   = bus.i_req_size;
          cnt_d   = '0;
          if (CHECK_ALIGN && is_misaligned(bus.i_req_size, bus.i_req_addr[1:0])) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = ERR_DATA;
          end else begin
            state_d = ST_REQ;
            stb_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        // An ack while stalled is a slave protocol error and is ignored.
        if (!bus.i_wb_stall && bus.i_wb_ack) begin
          state_d     = ST_RSP;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = bus.i_wb_data;
        end else if (timed_out) begin
          state_d     = ST_RSP;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = ERR_DATA;
        end else if (!bus.i_wb_stall) begin
          state_d = ST_WAIT;
          stb_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.i_wb_ack) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = bus.i_wb_data;
        end else if (timed_out) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = ERR_DATA;
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Self-checking bench for wb_master_port: table of single transactions with a
// cycle-accurate bus responder, plus reset and back-to-back sequences.
module tb_wb_master_port;
  import wb_master_port_pkg::*;

  localparam int unsigned TO    = 8;
  localparam int unsigned NEVER = 255;
  localparam int unsigned NVEC  = 11;

  logic i_clk = 1'b0;
  logic i_reset;

  wb_master_port_if bus ();

  wb_master_port #(.TIMEOUT_CYCLES(TO), .CHECK_ALIGN(1'b1)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int unsigned stall;        // stall cycles at the start of the stb phase
    int unsigned delay;        // ack this many cycles after stall drops (NEVER = no ack)
    logic        ack_in_stall; // also raise (illegal) ack during stall cycles
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int unsigned exp_lat;      // cycles from accept to rsp_valid
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned lat;
  } rsp_t;

  vec_t vecs [NVEC];
  rsp_t sb [$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Compare one observed response against the oldest expected one
  task automatic score(input string tag, input int unsigned cyc);
    rsp_t e;
    if (sb.size() == 0) begin
      check({tag, " unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " rsp_data"}, bus.o_rsp_data, e.data);
      check({tag, " rsp_err"}, {31'd0, bus.o_rsp_err}, {31'd0, e.err});
      check({tag, " latency"}, cyc, e.lat);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit          seen;
    bit          stb_ok;
    bit          stb_exp;
    bit          good_ack;
    int unsigned cyc;
    rsp_t        e;
    @(negedge i_clk);
    check({tag, " ready_idle"}, {31'd0, bus.o_req_ready}, 32'd1);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = v.we;
    bus.i_req_addr  = v.addr;
    bus.i_req_wdata = v.wdata;
    bus.i_req_size  = v.size;
    e.data = v.exp_data; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    seen   = 1'b0;
    stb_ok = 1'b1;
    for (cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge i_clk);
      bus.i_req_valid = 1'b0;
      stb_exp = (v.exp_lat > 1) && (cyc < v.exp_lat) && (cyc <= v.stall + 1);
      if (bus.o_wb_stb !== stb_exp) stb_ok = 1'b0;
      if (stb_exp && (bus.o_wb_addr !== v.addr || bus.o_wb_data !== v.wdata ||
                      bus.o_wb_sel !== v.size || bus.o_wb_we !== v.we)) stb_ok = 1'b0;
      if (bus.o_rsp_valid === 1'b1) begin
        seen = 1'b1;
        score(tag, cyc);
      end
      good_ack = (v.delay != NEVER) && (cyc == v.stall + 1 + v.delay);
      bus.i_wb_stall = !seen && (cyc <= v.stall);
      bus.i_wb_ack   = !seen && (good_ack || (v.ack_in_stall && cyc <= v.stall));
      bus.i_wb_data  = good_ack ? v.rdata : $urandom;
    end
    if (!seen) begin
      check({tag, " rsp_within_budget"}, 32'd0, 32'd1);
      sb.delete();
    end
    check({tag, " stb_phase"}, {31'd0, stb_ok}, 32'd1);
    @(negedge i_clk);
    check({tag, " rsp_one_cycle_then_ready"},
          {30'd0, bus.o_rsp_valid, bus.o_req_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rmem(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1111_1111 : 32'h2222_2222;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned rsp_cnt;
    bit          noresp_ok;
    bit          b2b_ok;
    rsp_t        e;

    //           we    addr           wdata          size    stl dly    ais   rdata          exp_data       err   lat
    vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         SEL_W,  0,  0,     1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[1]  = '{1'b1, 32'h0000_0203, 32'h0000_00AB, SEL_B,  3,  2,     1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 7};
    vecs[2]  = '{1'b0, 32'h0000_0101, 32'h0,         SEL_H,  0,  0,     1'b0, 32'h5555_5555, ERR_DATA,      1'b1, 1};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF0, 32'h0BAD_F00D, SEL_W,  0,  NEVER, 1'b0, 32'h0,         ERR_DATA,      1'b1, 9};
    vecs[4]  = '{1'b0, 32'h0000_0102, 32'h0,         SEL_HU, 1,  0,     1'b0, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0, 3};
    vecs[5]  = '{1'b0, 32'h0000_0106, 32'h0,         SEL_W,  0,  0,     1'b0, 32'h7777_7777, ERR_DATA,      1'b1, 1};
    vecs[6]  = '{1'b0, 32'h0000_0007, 32'h0,         SEL_BU, 0,  1,     1'b0, 32'h0000_00A5, 32'h0000_00A5, 1'b0, 3};
    vecs[7]  = '{1'b0, 32'h0000_0200, 32'h0,         SEL_W,  2,  0,     1'b1, 32'hC0DE_0001, 32'hC0DE_0001, 1'b0, 4};
    vecs[8]  = '{1'b0, 32'h0000_0300, 32'h0,         SEL_W,  20, NEVER, 1'b0, 32'h0,         ERR_DATA,      1'b1, 9};
    vecs[9]  = '{1'b0, 32'h0000_0400, 32'h0,         SEL_W,  0,  6,     1'b0, 32'h600D_0006, 32'h600D_0006, 1'b0, 8};
    vecs[10] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, SEL_W,  0,  0,     1'b0, 32'h0,         32'h0,         1'b0, 2};

    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0;
    bus.i_req_wdata = '0;   bus.i_req_size = '0;
    bus.i_wb_data = '0;     bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
    i_reset = 1'b0;
    #1;
    check("reset stb",       {31'd0, bus.o_wb_stb},    32'd0);
    check("reset rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    check("reset rsp_err",   {31'd0, bus.o_rsp_err},   32'd0);
    check("reset rsp_data",  bus.o_rsp_data,           32'd0);
    check("reset wb_addr",   bus.o_wb_addr,            32'd0);
    check("reset wb_data",   bus.o_wb_data,            32'd0);
    check("reset sel_we",    {28'd0, bus.o_wb_sel, bus.o_wb_we}, 32'd0);
    check("reset ready",     {31'd0, bus.o_req_ready}, 32'd1);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for ack; the ack arrives during and after reset
    @(negedge i_clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 32'h500; bus.i_req_size = SEL_W;
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    bus.i_wb_ack = 1'b1; bus.i_wb_data = 32'h0BAD_0BAD;
    #1;
    check("rst_wait stb",       {31'd0, bus.o_wb_stb},    32'd0);
    check("rst_wait rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    check("rst_wait ready",     {31'd0, bus.o_req_ready}, 32'd1);
    noresp_ok = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid !== 1'b0) noresp_ok = 1'b0;
    end
    i_reset = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid !== 1'b0 || bus.o_wb_stb !== 1'b0) noresp_ok = 1'b0;
    end
    bus.i_wb_ack = 1'b0;
    check("rst_wait late_ack_ignored", {31'd0, noresp_ok}, 32'd1);

    // Reset while the strobe is stalled: stb must drop without a clock edge
    @(negedge i_clk);
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h600;
    @(negedge i_clk);
    bus.i_req_valid = 1'b0; bus.i_wb_stall = 1'b1;
    @(negedge i_clk);
    check("rst_req stb_before", {31'd0, bus.o_wb_stb}, 32'd1);
    i_reset = 1'b0;
    #1;
    check("rst_req stb_async_drop", {31'd0, bus.o_wb_stb}, 32'd0);
    check("rst_req addr_cleared", bus.o_wb_addr, 32'd0);
    @(negedge i_clk);
    bus.i_wb_stall = 1'b0;
    i_reset = 1'b1;

    run_vec(vecs[0], "after_reset");

    // Back-to-back loads with i_req_valid held high; slave acks combinationally
    @(negedge i_clk);
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_size = SEL_W;
    bus.i_req_addr = 32'h10;
    e.data = 32'h1111_1111; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    e.data = 32'h2222_2222; e.err = 1'b0; e.lat = 5; sb.push_back(e);
    rsp_cnt = 0;
    b2b_ok  = 1'b1;
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge i_clk);
      if (c == 1) bus.i_req_addr = 32'h14;
      if (c == 4) bus.i_req_valid = 1'b0;
      if (bus.o_req_ready !== ((c == 3) || (c >= 6))) b2b_ok = 1'b0;
      if (bus.o_rsp_valid === 1'b1) begin
        rsp_cnt++;
        score($sformatf("b2b rsp%0d", rsp_cnt), c);
      end
      bus.i_wb_ack  = bus.o_wb_stb;
      bus.i_wb_data = bus.o_wb_stb ? rmem(bus.o_wb_addr) : $urandom;
    end
    bus.i_wb_ack = 1'b0;
    check("b2b rsp_count", rsp_cnt, 32'd2);
    check("b2b ready_pattern", {31'd0, b2b_ok}, 32'd1);
    sb.delete();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
